// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq command sequencer.
package alu_seq_pkg;

    localparam int ALU_SEQ_WIDTH = 16;
    localparam int ALU_SEQ_SEL_W = 2;

    localparam logic [1:0] ALU_SEL_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } alu_seq_state_e;

endpackage

// File: rtl/alu_seq.sv
// Valid/ready command sequencer driving an external combinational ALU, with opcode sweep mode.
// Optional response counter output enabled by defining ALU_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | ready for a command; A/B/ALU_Sel hold their previous values
// DRIVE | ALU inputs stable for one cycle; result captured at its end
// RESP  | response held until rsp_ready; sweeps step ALU_Sel and return to DRIVE
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int SEL_W = ALU_SEQ_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic             cmd_sweep,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [SEL_W-1:0] ALU_Sel,
    input  logic [WIDTH-1:0] ALU_Out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [SEL_W-1:0] rsp_sel,
    output logic             rsp_last,
    output logic             busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      rsp_count
`endif
);

    alu_seq_state_e   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sweep_q, sweep_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [SEL_W-1:0] rsp_sel_q, rsp_sel_d;
    logic             rsp_last_q, rsp_last_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_hs;

    assign rsp_hs = (state_q == RESP) && rsp_valid_q && rsp_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        sweep_d     = sweep_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_last_d  = rsp_last_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_sweep ? '0 : cmd_sel;
                    sweep_d = cmd_sweep;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                rsp_data_d  = ALU_Out;
                rsp_sel_d   = sel_q;
                rsp_last_d  = !sweep_q || (sel_q == SEL_W'(ALU_SEL_LAST));
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        // Sweep ends at ALU_SEL_LAST, so this never wraps.
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = DRIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            sweep_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_last_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            sweep_q     <= sweep_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_last_q  <= rsp_last_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign ALU_Sel   = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign rsp_last  = rsp_last_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] rsp_count_q, rsp_count_d;

    always_comb begin
        rsp_count_d = rsp_count_q;
        if (rsp_hs && (rsp_count_q != 16'hFFFF)) begin
            rsp_count_d = rsp_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_count_q <= '0;
        end else begin
            rsp_count_q <= rsp_count_d;
        end
    end

    assign rsp_count = rsp_count_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with an A+B+ALU_Sel ALU stub.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_sweep;
    logic [15:0] cmd_a, cmd_b;
    logic [1:0]  cmd_sel;
    logic [15:0] a_o, b_o, alu_out, rsp_data;
    logic [1:0]  alu_sel, rsp_sel;
    logic        rsp_valid, rsp_ready, rsp_last, busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] rsp_count;
`endif

    always #5 clk = ~clk;

    assign alu_out = a_o + b_o + {14'd0, alu_sel};

    alu_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_sweep(cmd_sweep),
        .A(a_o), .B(b_o), .ALU_Sel(alu_sel), .ALU_Out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_last(rsp_last),
        .busy(busy)
`ifdef ALU_SEQ_STATS_EN
        , .rsp_count(rsp_count)
`endif
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  sel;
        logic        last;
    } rsp_t;

    rsp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rx_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] sel, input logic sw);
        rsp_t e;
        if (sw) begin
            for (int i = 0; i < 4; i++) begin
                e.data = a + b + 16'(i);
                e.sel  = 2'(i);
                e.last = (i == 3);
                exp_q.push_back(e);
            end
        end else begin
            e.data = a + b + {14'd0, sel};
            e.sel  = sel;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: a response is consumed at the rising edge following this sample.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data 0x%0h sel %0d with empty scoreboard",
                         rsp_data, rsp_sel);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_sel", rsp_sel, e.sel);
                chk("rsp_last", rsp_last, e.last);
                rx_count++;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] sel, input logic sw);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_sweep = sw; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: cmd_ready still %0b after %0d cycles", cmd_ready, n);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++; errors++;
            $display("FAIL %s_drain_timeout: pending %0d busy %0b", name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_rsp_valid(input string name);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_rsp_valid_seen"}, rsp_valid, 1);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        chk({name, "_A"}, a_o, 0);
        chk({name, "_B"}, b_o, 0);
        chk({name, "_ALU_Sel"}, alu_sel, 0);
        chk({name, "_rsp_valid"}, rsp_valid, 0);
        chk({name, "_rsp_data"}, rsp_data, 0);
        chk({name, "_rsp_sel"}, rsp_sel, 0);
        chk({name, "_rsp_last"}, rsp_last, 0);
        chk({name, "_busy"}, busy, 0);
`ifdef ALU_SEQ_STATS_EN
        chk({name, "_rsp_count"}, rsp_count, 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, base;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0; cmd_sweep = 0; rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single command: 5+2+1 = 8
        push_exp(16'd5, 16'd2, 2'd1, 1'b0);
        send(16'd5, 16'd2, 2'd1, 1'b0);
        chk("single_A", a_o, 5);
        chk("single_B", b_o, 2);
        chk("single_ALU_Sel", alu_sel, 1);
        chk("single_busy", busy, 1);
        chk("single_cmd_ready_low", cmd_ready, 0);
        n = 0; lat = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
            if (rsp_valid && lat == 0) lat = n;
        end
        chk("single_rsp_latency_edges", lat + 1, 2);
        chk("single_cycles", n + 1, 3);
        drain("single");

        // Sweep: cmd_sel ignored, responses 7,8,9,10
        push_exp(16'd5, 16'd2, 2'd0, 1'b1);
        send(16'd5, 16'd2, 2'd3, 1'b1);
        chk("sweep_first_sel", alu_sel, 0);
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("sweep_cycles", n + 1, 9);
        drain("sweep");

        // Backpressure on the first sweep response
        base = rx_count;
        rsp_ready = 1'b0;
        push_exp(16'd100, 16'd20, 2'd0, 1'b1);
        send(16'd100, 16'd20, 2'd0, 1'b1);
        wait_rsp_valid("bp");
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_data_held", rsp_data, 120);
            chk("bp_sel_held", alu_sel, 0);
        end
        rsp_ready = 1'b1;
        drain("bp");
        chk("bp_all_received", rx_count - base, 4);

        // Command presented while busy must wait for IDLE
        rsp_ready = 1'b0;
        push_exp(16'd5, 16'd2, 2'd2, 1'b0);
        send(16'd5, 16'd2, 2'd2, 1'b0);
        wait_rsp_valid("busycmd");
        cmd_a = 16'd9; cmd_b = 16'd1; cmd_sel = 2'd3; cmd_sweep = 1'b0; cmd_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("busycmd_not_ready", cmd_ready, 0);
            chk("busycmd_A_held", a_o, 5);
        end
        push_exp(16'd9, 16'd1, 2'd3, 1'b0);
        rsp_ready = 1'b1;
        send(16'd9, 16'd1, 2'd3, 1'b0);
        chk("busycmd_new_A", a_o, 9);
        drain("busycmd");

        // Reset after the second sweep response
        base = rx_count;
        push_exp(16'd1, 16'd1, 2'd0, 1'b1);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        send(16'd1, 16'd1, 2'd0, 1'b1);
        n = 0;
        while (rx_count < base + 2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("midrst_two_rsp", rx_count - base, 2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            chk("midrst_no_replay", rsp_valid, 0);
        end
        chk("midrst_scoreboard_empty", exp_q.size(), 0);

        // Two sweeps and one single; second sweep wraps the 16-bit sum
        push_exp(16'd3, 16'd4, 2'd0, 1'b1);
        send(16'd3, 16'd4, 2'd0, 1'b1);
        drain("stats_sweep1");
        push_exp(16'd0, 16'hFFFF, 2'd0, 1'b1);
        send(16'd0, 16'hFFFF, 2'd0, 1'b1);
        drain("stats_sweep2");
        push_exp(16'h1234, 16'h1111, 2'd0, 1'b0);
        send(16'h1234, 16'h1111, 2'd0, 1'b0);
        drain("stats_single");
        chk("final_A_held", a_o, 16'h1234);
        chk("final_cmd_ready", cmd_ready, 1);
`ifdef ALU_SEQ_STATS_EN
        chk("rsp_count", rsp_count, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer that sits in front of the combinational 16-bit ALU and acts as its initiator. It accepts operand/opcode commands over a valid/ready handshake, drives the ALU's `A`, `B` and `ALU_Sel` inputs from registers, and captures `ALU_Out` one cycle later. It returns each result over a second valid/ready handshake. A sweep mode issues all four `ALU_Sel` codes for one operand pair, which is the automated replacement for hand-stepped opcode sweeps.

## Interface
- `WIDTH`, 16: operand/result width.
- `SEL_W`, 2: opcode width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_a` in WIDTH: operand A.
- `cmd_b` in WIDTH: operand B.
- `cmd_sel` in SEL_W: opcode. Ignored when `cmd_sweep`=1.
- `cmd_sweep` in 1: when 1, issue opcodes 0,1,2,3 in order.
- `A` out WIDTH: ALU operand A (registered).
- `B` out WIDTH: ALU operand B (registered).
- `ALU_Sel` out SEL_W: ALU opcode (registered).
- `ALU_Out` in WIDTH: ALU result (combinational from `A`/`B`/`ALU_Sel`).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out WIDTH: captured `ALU_Out`.
- `rsp_sel` out SEL_W: opcode that produced `rsp_data`.
- `rsp_last` out 1: final response of the command.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `A`←`cmd_a`, `B`←`cmd_b`, and `ALU_Sel`←(`cmd_sweep` ? 0 : `cmd_sel`).
  - Latch the sweep flag. Go to DRIVE.
- DRIVE:
  - Exactly one cycle, during which the ALU settles.
  - At the end of DRIVE: `rsp_data`←`ALU_Out`, `rsp_sel`←`ALU_Sel`, `rsp_last`←(!sweep || `ALU_Sel`==3), `rsp_valid`←1.
  - Go to RESP.
- RESP:
  - Hold all `rsp_*` stable until `rsp_valid && rsp_ready`.
  - On that handshake, if `rsp_last`: `rsp_valid`←0, go to IDLE.
  - Otherwise: `rsp_valid`←0, `ALU_Sel`←`ALU_Sel`+1, go to DRIVE.
- `cmd_ready`=0 in DRIVE and RESP; commands there are not accepted.
- `A`, `B` and `ALU_Sel` hold their last values after completion; they are not cleared on return to IDLE.
- Result width equals WIDTH; no extension or truncation. `ALU_Sel` increment never wraps because sweep stops at 3.
- Reset mid-operation: all state is cleared and any in-flight response is dropped, not replayed.

## Timing
- Reset values: `cmd_ready`=1, `A`=0, `B`=0, `ALU_Sel`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_sel`=0, `rsp_last`=0, `busy`=0, FSM=IDLE.
- Command handshake on edge E0 → `A`/`B`/`ALU_Sel` valid after E0 → `rsp_valid`=1 after E1. Latency is 2 edges.
- Response handshake on edge Ek (non-last) → next `rsp_valid`=1 after Ek+1.
- With `rsp_ready` tied high:
  - A single command occupies 3 cycles: IDLE accept, DRIVE, RESP.
  - A sweep occupies 1 + 4×2 cycles.
- `cmd_ready` reasserts the cycle after the last response handshake. Back-to-back commands therefore incur one IDLE cycle.

## Configuration
- `ALU_SEQ_STATS_EN` defined:
  - Adds output `rsp_count` (16 bit, reset 0).
  - Increments on every response handshake and saturates at 16'hFFFF.
- `ALU_SEQ_STATS_EN` undefined: port and counter are absent. All other behaviour is identical.

## Structure
- `alu_seq_pkg` contains:
  - the `alu_seq_state_e` enum (IDLE, DRIVE, RESP);
  - `ALU_SEL_LAST` = 2'd3;
  - the default width constants.
- No sub-module: the FSM and datapath live in `alu_seq`.
- The ALU is instantiated beside `alu_seq` by the parent, not inside it.

## Test plan
- The bench ALU stub computes `ALU_Out` = `A`+`B`+`ALU_Sel`.
- Single command: `cmd_a`=5, `cmd_b`=2, `cmd_sel`=1, `rsp_ready`=1 → `rsp_data`=8, `rsp_sel`=1, `rsp_last`=1. `rsp_valid` rises 2 edges after accept; `cmd_ready` returns the next cycle.
- Sweep: `cmd_a`=5, `cmd_b`=2, `cmd_sweep`=1 → four responses with `rsp_data` 7,8,9,10 and `rsp_sel` 0..3. `rsp_last` is 1 only on the fourth.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during a sweep → `rsp_valid`/`rsp_data` stay stable, `ALU_Sel` does not advance, and no response is lost.
- Command while busy: assert `cmd_valid` with `cmd_a`=9 during RESP → no accept until IDLE. The later result reflects `cmd_a`=9.
- Reset mid-sweep: drop `rsp_n` after the second response → every output returns to its reset value immediately. No further responses appear after release.
- Stats (`ALU_SEQ_STATS_EN`): two sweeps plus one single command → `rsp_count`=9.
